tdc_coarse_ctrl: RTL and testbench

//  Sequencer/arbiter for one ETROC2 TDC channel's coarse-phase ripple counters (A on rising, B on falling Clk_In).
//  Per measurement window: releases counter reset, issues TOA/TOT latch strobes, arbitrates hit vs calibration.

---
 rtl/tdc_coarse_ctrl_if.sv | 32 +++
 rtl/tdc_coarse_ctrl.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_tdc_coarse_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdc_coarse_ctrl_if.sv
// ---------------------------------------------------------------------------
// tdc_coarse_ctrl_if
// Result delivery bus of the TDC coarse-phase controller: one decoded
// measurement per transfer over a valid/ready handshake.
//   Out_Valid  result valid (held until accepted)
//   Out_Ready  consumer accepts the current result
//   Out_Type   00 hit, 01 calibration, 10 timeout (no stop seen)
//   Out_TOA    decoded TOA coarse code
//   Out_TOT    decoded TOT coarse code (0 for timeout)
//   Out_Width  (Out_TOT - Out_TOA) mod 16 (0 for timeout)
//   Out_Err    A/B counter inconsistency in either decode
// master = controller side, slave = consumer side.
// ---------------------------------------------------------------------------
interface tdc_coarse_ctrl_if;
    logic       Out_Valid;
    logic       Out_Ready;
    logic [1:0] Out_Type;
    logic [3:0] Out_TOA;
    logic [3:0] Out_TOT;
    logic [3:0] Out_Width;
    logic       Out_Err;

    modport master (
        output Out_Valid, Out_Type, Out_TOA, Out_TOT, Out_Width, Out_Err,
        input  Out_Ready
    );

    modport slave (
        input  Out_Valid, Out_Type, Out_TOA, Out_TOT, Out_Width, Out_Err,
        output Out_Ready
    );
endinterface

// File: rtl/tdc_coarse_ctrl.sv
// ---------------------------------------------------------------------------
// tdc_coarse_ctrl
// Sequencer/arbiter for one TDC channel's coarse-phase ripple counters
// (A counts on rising, B on falling Clk_In). Per window it releases the
// counter reset, strobes TOA/TOT snapshots, arbitrates hit vs calibration,
// then decodes the latched A/B pairs into 4-bit coarse codes.
// Ports:
//   Clk_In, RST              clock, synchronous active-high reset
//   Enable                   allows new windows
//   Hit_Start, Hit_Stop      1-cycle TOA / TOT pulses
//   Cal_Req / Cal_Ack        calibration request level / accept pulse
//   Cnt_RSTN                 active-low reset to the ripple counters
//   TOA_Latch, TOT_Latch     1-cycle snapshot strobes
//   TOA_CntA/B, TOT_CntA/B   latched counter snapshots
//   Drop_Cnt                 saturating count of ignored Hit_Start pulses
//   out_bus                  result valid/ready bus (tdc_coarse_ctrl_if)
// ---------------------------------------------------------------------------
module tdc_coarse_ctrl #(
    parameter int WIN_LEN    = 16,
    parameter int CAL_DLY    = 3,
    parameter int CAL_LEN    = 4,
    parameter int CAL_STARVE = 4
) (
    input  logic                     Clk_In,
    input  logic                     RST,
    input  logic                     Enable,
    input  logic                     Hit_Start,
    input  logic                     Hit_Stop,
    input  logic                     Cal_Req,
    output logic                     Cal_Ack,
    output logic                     Cnt_RSTN,
    output logic                     TOA_Latch,
    output logic                     TOT_Latch,
    input  logic [2:0]               TOA_CntA,
    input  logic [2:0]               TOA_CntB,
    input  logic [2:0]               TOT_CntA,
    input  logic [2:0]               TOT_CntB,
    output logic [7:0]               Drop_Cnt,
    tdc_coarse_ctrl_if.master        out_bus
);

    localparam int TMR_MAX = (WIN_LEN > (CAL_DLY + CAL_LEN)) ? WIN_LEN : (CAL_DLY + CAL_LEN);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int STV_W   = $clog2(CAL_STARVE + 1);

    localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WIN_LEN - 1);
    localparam logic [TMR_W-1:0] CAL_TOA_AT  = TMR_W'(CAL_DLY - 1);
    localparam logic [TMR_W-1:0] CAL_TOT_AT  = TMR_W'(CAL_DLY + CAL_LEN - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(2);
    localparam logic [STV_W-1:0] STARVE_MAX  = STV_W'(CAL_STARVE);

    localparam logic [1:0] KIND_HIT = 2'b00;
    localparam logic [1:0] KIND_CAL = 2'b01;
    localparam logic [1:0] KIND_TMO = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_WAIT_TOT = 3'd2,
        S_CAL_ARM  = 3'd3,
        S_SETTLE   = 3'd4,
        S_ENCODE   = 3'd5,
        S_OUT      = 3'd6
    } state_t;

    // Coarse decode: B lags A by half a cycle, so B==A-1 means the falling
    // edge has not yet been counted and the code sits one below {A,0}.
    // Returns {err, code}.
    function automatic logic [4:0] decode_ab(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] base;
        base = {a, 1'b0};
        if (b == a) begin
            decode_ab = {1'b0, base};
        end else if (b == (a - 3'd1)) begin
            decode_ab = {1'b0, base - 4'd1};
        end else begin
            decode_ab = {1'b1, base};
        end
    endfunction

    state_t             state_r, state_nxt_s;
    logic [TMR_W-1:0]   tmr_r;
    logic [STV_W-1:0]   starve_r;
    logic [1:0]         kind_r, kind_nxt_s;
    logic               tmr_clr_s, toa_set_s, tot_set_s;
    logic               starve_inc_s, starve_clr_s, kind_set_s;
    logic               encode_s, accept_s, starve_full_s;
    logic [4:0]         toa_dec_s, tot_dec_s;

    logic               cnt_rstn_r, toa_latch_r, tot_latch_r;
    logic [7:0]         drop_r;
    logic               out_valid_r, out_err_r;
    logic [1:0]         out_type_r;
    logic [3:0]         out_toa_r, out_tot_r, out_width_r;

    assign starve_full_s = (starve_r == STARVE_MAX);
    assign toa_dec_s     = decode_ab(TOA_CntA, TOA_CntB);
    assign tot_dec_s     = decode_ab(TOT_CntA, TOT_CntB);

    // FSM state register
    always_ff @(posedge Clk_In) begin
        if (RST) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state and per-cycle control decode
    always_comb begin
        state_nxt_s  = state_r;
        kind_nxt_s   = KIND_HIT;
        kind_set_s   = 1'b0;
        tmr_clr_s    = 1'b0;
        toa_set_s    = 1'b0;
        tot_set_s    = 1'b0;
        starve_inc_s = 1'b0;
        starve_clr_s = 1'b0;
        encode_s     = 1'b0;
        accept_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (Enable) begin
                    tmr_clr_s  = 1'b1;
                    kind_set_s = 1'b1;
                    // Calibration wins when nothing competes or hits have starved it.
                    if (Cal_Req && (starve_full_s || !Hit_Start)) begin
                        state_nxt_s = S_CAL_ARM;
                        kind_nxt_s  = KIND_CAL;
                    end else begin
                        state_nxt_s = S_ARM;
                        kind_nxt_s  = KIND_HIT;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_ARM: begin
                if (Hit_Start) begin
                    toa_set_s   = 1'b1;
                    tmr_clr_s   = 1'b1;
                    state_nxt_s = S_WAIT_TOT;
                    if (Cal_Req && !starve_full_s) begin
                        starve_inc_s = 1'b1;
                    end else begin
                        starve_inc_s = 1'b0;
                    end
                end else if ((tmr_r == WIN_LAST) || !Enable) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_ARM;
                end
            end
            S_WAIT_TOT: begin
                if (Hit_Stop) begin
                    tot_set_s   = 1'b1;
                    tmr_clr_s   = 1'b1;
                    state_nxt_s = S_SETTLE;
                end else if (tmr_r == WIN_LAST) begin
                    kind_set_s  = 1'b1;
                    kind_nxt_s  = KIND_TMO;
                    state_nxt_s = S_ENCODE;
                end else begin
                    state_nxt_s = S_WAIT_TOT;
                end
            end
            S_CAL_ARM: begin
                starve_clr_s = 1'b1;
                if (tmr_r == CAL_TOA_AT) begin
                    toa_set_s = 1'b1;
                end else begin
                    toa_set_s = 1'b0;
                end
                if (tmr_r == CAL_TOT_AT) begin
                    tot_set_s   = 1'b1;
                    tmr_clr_s   = 1'b1;
                    state_nxt_s = S_SETTLE;
                end else begin
                    state_nxt_s = S_CAL_ARM;
                end
            end
            S_SETTLE: begin
                // Latch cycle plus two more so the snapshot has settled.
                if (tmr_r == SETTLE_LAST) begin
                    state_nxt_s = S_ENCODE;
                end else begin
                    state_nxt_s = S_SETTLE;
                end
            end
            S_ENCODE: begin
                encode_s    = 1'b1;
                state_nxt_s = S_OUT;
            end
            S_OUT: begin
                if (out_bus.Out_Ready) begin
                    accept_s    = 1'b1;
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_OUT;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Window/settle timer, cleared on every timed-state entry
    always_ff @(posedge Clk_In) begin
        if (RST || tmr_clr_s) begin
            tmr_r <= {TMR_W{1'b0}};
        end else begin
            tmr_r <= tmr_r + 1'b1;
        end
    end

    // Starvation counter, measurement kind and strobes
    always_ff @(posedge Clk_In) begin
        if (RST) begin
            starve_r    <= {STV_W{1'b0}};
            kind_r      <= KIND_HIT;
            cnt_rstn_r  <= 1'b0;
            toa_latch_r <= 1'b0;
            tot_latch_r <= 1'b0;
        end else begin
            if (starve_clr_s) begin
                starve_r <= {STV_W{1'b0}};
            end else if (starve_inc_s) begin
                starve_r <= starve_r + 1'b1;
            end
            if (kind_set_s) begin
                kind_r <= kind_nxt_s;
            end
            // Counters run in every state except IDLE and OUT.
            cnt_rstn_r  <= (state_nxt_s != S_IDLE) && (state_nxt_s != S_OUT);
            toa_latch_r <= toa_set_s;
            tot_latch_r <= tot_set_s;
        end
    end

    // Dropped Hit_Start counter: any pulse outside ARM, saturating
    always_ff @(posedge Clk_In) begin
        if (RST) begin
            drop_r <= 8'd0;
        end else if (Hit_Start && (state_r != S_ARM) && (drop_r != 8'd255)) begin
            drop_r <= drop_r + 8'd1;
        end
    end

    // Result registers, loaded in ENCODE and held until accepted
    always_ff @(posedge Clk_In) begin
        if (RST) begin
            out_valid_r <= 1'b0;
            out_type_r  <= 2'b00;
            out_toa_r   <= 4'd0;
            out_tot_r   <= 4'd0;
            out_width_r <= 4'd0;
            out_err_r   <= 1'b0;
        end else if (encode_s) begin
            out_valid_r <= 1'b1;
            out_type_r  <= kind_r;
            out_toa_r   <= toa_dec_s[3:0];
            if (kind_r == KIND_TMO) begin
                out_tot_r   <= 4'd0;
                out_width_r <= 4'd0;
                out_err_r   <= toa_dec_s[4];
            end else begin
                out_tot_r   <= tot_dec_s[3:0];
                out_width_r <= tot_dec_s[3:0] - toa_dec_s[3:0];
                out_err_r   <= toa_dec_s[4] | tot_dec_s[4];
            end
        end else if (accept_s) begin
            out_valid_r <= 1'b0;
        end
    end

    // Cal_Ack marks the accepting cycle itself, so it follows Out_Ready directly.
    assign Cal_Ack           = accept_s && (out_type_r == KIND_CAL);
    assign Cnt_RSTN          = cnt_rstn_r;
    assign TOA_Latch         = toa_latch_r;
    assign TOT_Latch         = tot_latch_r;
    assign Drop_Cnt          = drop_r;
    assign out_bus.Out_Valid = out_valid_r;
    assign out_bus.Out_Type  = out_type_r;
    assign out_bus.Out_TOA   = out_toa_r;
    assign out_bus.Out_TOT   = out_tot_r;
    assign out_bus.Out_Width = out_width_r;
    assign out_bus.Out_Err   = out_err_r;

endmodule

// File: tb/tb_tdc_coarse_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tdc_coarse_ctrl
// Directed bench for tdc_coarse_ctrl. Inputs change and outputs are sampled
// on the falling edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_tdc_coarse_ctrl;

    logic       Clk_In = 1'b0;
    logic       RST;
    logic       Enable;
    logic       Hit_Start;
    logic       Hit_Stop;
    logic       Cal_Req;
    logic       Cal_Ack;
    logic       Cnt_RSTN;
    logic       TOA_Latch;
    logic       TOT_Latch;
    logic [2:0] TOA_CntA, TOA_CntB, TOT_CntA, TOT_CntB;
    logic [7:0] Drop_Cnt;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int exp_drop  = 0;

    tdc_coarse_ctrl_if bus_if ();

    tdc_coarse_ctrl dut (
        .Clk_In    (Clk_In),
        .RST       (RST),
        .Enable    (Enable),
        .Hit_Start (Hit_Start),
        .Hit_Stop  (Hit_Stop),
        .Cal_Req   (Cal_Req),
        .Cal_Ack   (Cal_Ack),
        .Cnt_RSTN  (Cnt_RSTN),
        .TOA_Latch (TOA_Latch),
        .TOT_Latch (TOT_Latch),
        .TOA_CntA  (TOA_CntA),
        .TOA_CntB  (TOA_CntB),
        .TOT_CntA  (TOT_CntA),
        .TOT_CntB  (TOT_CntB),
        .Drop_Cnt  (Drop_Cnt),
        .out_bus   (bus_if)
    );

    // 10-unit clock
    always #5 Clk_In = ~Clk_In;

    task automatic check_val(input string tag, input int obs, input int exp);
        total_cnt++;
        if (obs != exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk_In);
    endtask

    // Wait (bounded) until the counters are released, i.e. a window is open.
    task automatic wait_arm();
        int n;
        n = 0;
        while (!Cnt_RSTN && n < 20) begin
            tick();
            n++;
        end
        check_val("arm_wait", int'(Cnt_RSTN), 1);
    endtask

    // One hit measurement: start in ARM, stop after 'gap' cycles. Returns the
    // number of falling edges from the Hit_Stop cycle to Out_Valid.
    task automatic run_hit(input logic [2:0] ta, input logic [2:0] tb_b,
                           input logic [2:0] oa, input logic [2:0] ob,
                           input int gap, output int lat);
        TOA_CntA = ta; TOA_CntB = tb_b; TOT_CntA = oa; TOT_CntB = ob;
        wait_arm();
        Hit_Start = 1'b1;
        tick();
        Hit_Start = 1'b0;
        check_val("toa_latch", int'(TOA_Latch), 1);
        for (int i = 0; i < gap; i++) tick();
        Hit_Stop = 1'b1;
        tick();
        Hit_Stop = 1'b0;
        check_val("tot_latch", int'(TOT_Latch), 1);
        lat = 1;
        while (!bus_if.Out_Valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic accept(input int exp_ack);
        bus_if.Out_Ready = 1'b1;
        #1;
        check_val("cal_ack", int'(Cal_Ack), exp_ack);
        tick();
        check_val("valid_drop", int'(bus_if.Out_Valid), 0);
        bus_if.Out_Ready = 1'b0;
    endtask

    task automatic check_out(input string tag, input int typ, input int toa,
                             input int tot, input int wid, input int err);
        check_val({tag, "_type"},  int'(bus_if.Out_Type),  typ);
        check_val({tag, "_toa"},   int'(bus_if.Out_TOA),   toa);
        check_val({tag, "_tot"},   int'(bus_if.Out_TOT),   tot);
        check_val({tag, "_width"}, int'(bus_if.Out_Width), wid);
        check_val({tag, "_err"},   int'(bus_if.Out_Err),   err);
    endtask

    initial begin
        int lat, cnt, d, s;
        bit stable;

        RST = 1'b1; Enable = 1'b0; Hit_Start = 1'b0; Hit_Stop = 1'b0; Cal_Req = 1'b0;
        bus_if.Out_Ready = 1'b0;
        TOA_CntA = 3'd0; TOA_CntB = 3'd0; TOT_CntA = 3'd0; TOT_CntB = 3'd0;
        repeat (3) tick();

        // Reset state
        check_val("rst_cnt_rstn", int'(Cnt_RSTN), 0);
        check_val("rst_toa_latch", int'(TOA_Latch), 0);
        check_val("rst_tot_latch", int'(TOT_Latch), 0);
        check_val("rst_valid", int'(bus_if.Out_Valid), 0);
        check_val("rst_drop", int'(Drop_Cnt), 0);
        check_val("rst_cal_ack", int'(Cal_Ack), 0);
        RST = 1'b0;
        tick();

        // 1: basic hit, latency Hit_Stop -> Out_Valid = 5
        Enable = 1'b1;
        run_hit(3'd3, 3'd3, 3'd5, 3'd4, 2, lat);
        check_val("hit_latency", lat, 5);
        check_out("hit", 0, 6, 9, 3, 0);
        accept(0);

        // 2: wrap of the width across code 15 -> 0
        run_hit(3'd7, 3'd7, 3'd1, 3'd0, 3, lat);
        check_val("wrap_latency", lat, 5);
        check_out("wrap", 0, 14, 1, 3, 0);
        accept(0);

        // 3: inconsistent TOA pair, inconsistent TOT pair, decode wrap 0-1
        run_hit(3'd2, 3'd5, 3'd5, 3'd4, 1, lat);
        check_out("toa_err", 0, 4, 9, 5, 1);
        accept(0);
        run_hit(3'd3, 3'd3, 3'd5, 3'd1, 1, lat);
        check_out("tot_err", 0, 6, 10, 4, 1);
        accept(0);
        run_hit(3'd0, 3'd7, 3'd2, 3'd2, 1, lat);
        check_out("dec_wrap", 0, 15, 4, 5, 0);
        accept(0);

        // 4a: no stop -> timeout result after 16 WAIT_TOT cycles
        TOA_CntA = 3'd4; TOA_CntB = 3'd3; TOT_CntA = 3'd6; TOT_CntB = 3'd6;
        wait_arm();
        Hit_Start = 1'b1;
        lat = 0;
        while (!bus_if.Out_Valid && lat < 40) begin
            tick();
            Hit_Start = 1'b0;
            lat++;
        end
        check_val("tmo_latency", lat, 18);
        check_out("tmo", 2, 7, 0, 0, 0);
        accept(0);

        // 4b: no start -> ARM lasts exactly 16 cycles, then IDLE, no result
        wait_arm();
        cnt = 1;
        tick();
        while (Cnt_RSTN && cnt < 40) begin
            cnt++;
            tick();
        end
        check_val("arm_window", cnt, 16);
        check_val("arm_tmo_no_valid", int'(bus_if.Out_Valid), 0);
        Enable = 1'b0;
        repeat (3) tick();
        check_val("idle_disabled", int'(Cnt_RSTN), 0);

        // Enable dropped while armed -> back to IDLE
        Enable = 1'b1;
        wait_arm();
        Enable = 1'b0;
        tick();
        check_val("arm_disable", int'(Cnt_RSTN), 0);
        repeat (2) tick();

        // 5: arbitration, Cal_Req held and Hit_Start offered in every IDLE
        Cal_Req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            Hit_Start = 1'b1;
            Enable = 1'b1;
            tick();
            exp_drop++;
            run_hit(3'd3, 3'd3, 3'd5, 3'd4, 1, lat);
            check_val("arb_hit_type", int'(bus_if.Out_Type), 0);
            accept(0);
        end
        Hit_Start = 1'b1;
        tick();
        Hit_Start = 1'b0;
        exp_drop++;
        check_val("cal_no_early_latch", int'(TOA_Latch), 0);
        d = 0;
        while (!TOA_Latch && d < 20) begin
            tick();
            d++;
        end
        check_val("cal_toa_delay", d, 3);
        s = 0;
        while (!TOT_Latch && s < 20) begin
            tick();
            s++;
        end
        check_val("cal_latch_spacing", s, 4);
        lat = 0;
        while (!bus_if.Out_Valid && lat < 40) begin
            tick();
            lat++;
        end
        check_val("cal_latency", lat, 4);
        check_out("cal", 1, 6, 9, 3, 0);
        check_val("cal_ack_before", int'(Cal_Ack), 0);
        accept(1);
        check_val("cal_ack_once", int'(Cal_Ack), 0);
        Cal_Req = 1'b0;
        check_val("drop_after_arb", int'(Drop_Cnt), exp_drop);

        // 6a: backpressure - result held, snapshot changes ignored, extra start dropped
        run_hit(3'd3, 3'd3, 3'd5, 3'd4, 2, lat);
        TOA_CntA = 3'd1; TOA_CntB = 3'd6; TOT_CntA = 3'd2; TOT_CntB = 3'd2;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            Hit_Start = (i == 3);
            tick();
            if (!(bus_if.Out_Valid && bus_if.Out_TOA == 4'd6 && bus_if.Out_TOT == 4'd9 &&
                  bus_if.Out_Width == 4'd3 && !bus_if.Out_Err && bus_if.Out_Type == 2'b00))
                stable = 1'b0;
        end
        Hit_Start = 1'b0;
        exp_drop++;
        check_val("bp_stable", int'(stable), 1);
        check_val("bp_drop", int'(Drop_Cnt), exp_drop);
        Enable = 1'b0;
        accept(0);
        repeat (2) tick();

        // Drop counter saturates at 255
        for (int i = 0; i < 300; i++) begin
            Hit_Start = 1'b1;
            tick();
            Hit_Start = 1'b0;
            tick();
        end
        check_val("drop_sat", int'(Drop_Cnt), 255);

        // 6b: reset while waiting for stop
        Enable = 1'b1;
        wait_arm();
        Hit_Start = 1'b1;
        tick();
        Hit_Start = 1'b0;
        tick();
        check_val("pre_rst_rstn", int'(Cnt_RSTN), 1);
        RST = 1'b1;
        Enable = 1'b0;
        tick();
        check_val("mid_rst_rstn", int'(Cnt_RSTN), 0);
        check_val("mid_rst_drop", int'(Drop_Cnt), 0);
        check_val("mid_rst_valid", int'(bus_if.Out_Valid), 0);
        check_val("mid_rst_toa", int'(bus_if.Out_TOA), 0);
        check_val("mid_rst_latch", int'(TOA_Latch), 0);
        RST = 1'b0;
        Hit_Stop = 1'b1;
        tick();
        Hit_Stop = 1'b0;
        repeat (2) tick();
        check_val("post_rst_tot_latch", int'(TOT_Latch), 0);
        check_val("post_rst_valid", int'(bus_if.Out_Valid), 0);
        check_val("post_rst_idle", int'(Cnt_RSTN), 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
